// File: rtl/shift_sub_div.sv
// Restoring shift-subtract mantissa divider: one quotient bit per clock.
// It returns floor(dividend * 2^25 / divisor), a sticky remainder flag and a divide-by-zero flag.
module shift_sub_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [25:0] quotient,
  output logic        sticky,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [24:0] rem, rem_next;
  logic [23:0] dvsr;
  logic [25:0] q;
  logic [4:0]  cnt;
  logic        sticky_q, dz_q;
  logic [25:0] diff;
  logic        borrow;

  // The extra top bit of diff is the borrow out of the 25-bit subtract.
  assign diff     = {1'b0, rem} - {2'b00, dvsr};
  assign borrow   = diff[25];
  assign rem_next = borrow ? (rem << 1) : (diff[24:0] << 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd1) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dvsr     <= '0;
      q        <= '0;
      cnt      <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sticky_q <= 1'b0;
            if (divisor == '0) begin
              dz_q <= 1'b1;
              q    <= '1;
            end else begin
              rem  <= {1'b0, dividend};
              dvsr <= divisor;
              q    <= '0;
              cnt  <= 5'd26;
              dz_q <= 1'b0;
            end
          end
        end
        RUN: begin
          q   <= {q[24:0], ~borrow};
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) sticky_q <= (rem_next != '0);
        end
        default: ;
      endcase
    end
  end

  assign quotient = q;
  assign sticky   = sticky_q;
  assign dz       = dz_q;

endmodule
